// File: rtl/config_menu.sv
`default_nettype none
// ============================================================================
//  Module      : config_menu
//  Description : Keypad-driven configuration editor for bip/lock times and
//                PIN slots, with BCD display and active-low completion handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_menu #(
    parameter int NUM_PINS    = 4,
    parameter int PIN_DIGITS  = 4,
    parameter int TIME_MIN    = 5,
    parameter int TIME_MAX    = 60,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int PIN_W      = 1 + 4 * PIN_DIGITS,
    localparam int CFG_W      = 15 + NUM_PINS * PIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             setup_on,
    input  logic [CFG_W-1:0] cfg_old,
    output logic [CFG_W-1:0] cfg_new,
    output logic [23:0]      bcd_out,
    output logic             bcd_enable,
    output logic             setup_end,
    output logic             setup_abort
);

    localparam int              TO_W        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] c_to_last   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0]      c_last_step = 5'(2 * NUM_PINS + 2);
    localparam logic [23:0]     c_blank     = 24'hFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_EDIT     = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_OFF = 3'd4
    } state_t;

    state_t            r_state;
    logic [4:0]        r_step;
    logic [CFG_W-1:0]  r_snap;
    logic              r_key_prev;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_key_evt;
    logic              w_abort;
    logic [CFG_W-1:0]  w_load_cfg;
    logic [CFG_W-1:0]  w_edit_cfg;

    function automatic logic [3:0] tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] units(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    // New value is (old units)*10 + digit, so two keystrokes enter a two-digit number.
    function automatic logic [6:0] clamp_time(input logic [6:0] v, input logic [3:0] d);
        logic [7:0] t;
        t = 8'(units(v)) * 8'd10 + 8'(d);
        if (t < 8'(TIME_MIN))
            t = 8'(TIME_MIN);
        else if (t > 8'(TIME_MAX))
            t = 8'(TIME_MAX);
        return t[6:0];
    endfunction

    function automatic logic [23:0] disp(input logic [4:0] s, input logic [CFG_W-1:0] c);
        logic [15:0] low;
        low = 16'hFFFF;
        if (s == 5'd1)
            low = {12'hFFF, 3'b000, c[0]};
        else if (s == 5'd2)
            low = {8'hFF, tens(c[7:1]), units(c[7:1])};
        else if (s == 5'd3)
            low = {8'hFF, tens(c[14:8]), units(c[14:8])};
        for (int i = 0; i < NUM_PINS; i++) begin
            if (s == 5'(4 + 2 * i))
                low = c[15 + i * PIN_W + 1 +: 16];
            if ((i > 0) && (s == 5'(3 + 2 * i)))
                low = {12'hFFF, 3'b000, c[15 + i * PIN_W]};
        end
        return {4'(s / 5'd10), 4'(s % 5'd10), low};
    endfunction

    function automatic logic [CFG_W-1:0] apply_digit(input logic [4:0] s,
                                                     input logic [CFG_W-1:0] c,
                                                     input logic [3:0] d);
        logic [CFG_W-1:0] r;
        r = c;
        if (s == 5'd1) begin
            if (d < 4'd2)
                r[0] = d[0];
        end else if (s == 5'd2) begin
            r[7:1] = clamp_time(c[7:1], d);
        end else if (s == 5'd3) begin
            r[14:8] = clamp_time(c[14:8], d);
        end
        for (int i = 0; i < NUM_PINS; i++) begin
            if (s == 5'(4 + 2 * i))
                r[15 + i * PIN_W + 1 +: 4 * PIN_DIGITS] =
                    {c[15 + i * PIN_W + 1 +: 4 * PIN_DIGITS - 4], d};
            if ((i > 0) && (s == 5'(3 + 2 * i)) && (d < 4'd2))
                r[15 + i * PIN_W] = d[0];
        end
        return r;
    endfunction

    always_comb begin
        w_key_evt  = key_valid & ~r_key_prev;
        w_load_cfg = cfg_old;
        w_load_cfg[15] = 1'b1;
        w_edit_cfg = apply_digit(r_step, cfg_new, key_code);
        // Withdrawal beats everything; a key event in the timeout cycle wins over the timeout.
        w_abort    = !setup_on
                   || (w_key_evt && (key_code == 4'hE))
                   || (!w_key_evt && (r_to_cnt == c_to_last));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= 5'd1;
            cfg_new     <= '0;
            r_snap      <= '0;
            bcd_out     <= c_blank;
            bcd_enable  <= 1'b0;
            setup_end   <= 1'b1;
            setup_abort <= 1'b0;
            r_key_prev  <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_key_prev <= key_valid;
            case (r_state)
                S_IDLE: begin
                    setup_end  <= 1'b1;
                    bcd_enable <= 1'b0;
                    bcd_out    <= c_blank;
                    if (setup_on)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    cfg_new     <= w_load_cfg;
                    r_snap      <= w_load_cfg;
                    r_step      <= 5'd1;
                    r_to_cnt    <= '0;
                    setup_abort <= 1'b0;
                    bcd_enable  <= 1'b1;
                    bcd_out     <= disp(5'd1, w_load_cfg);
                    r_state     <= S_EDIT;
                end
                S_EDIT: begin
                    if (w_abort) begin
                        r_state     <= S_DONE;
                        setup_abort <= 1'b1;
                        cfg_new     <= r_snap;
                    end else if (w_key_evt) begin
                        r_to_cnt <= '0;
                        if (key_code <= 4'd9) begin
                            cfg_new <= w_edit_cfg;
                            bcd_out <= disp(r_step, w_edit_cfg);
                        end else if (key_code == 4'hF) begin
                            if (r_step == c_last_step) begin
                                r_state     <= S_DONE;
                                setup_abort <= 1'b0;
                            end else begin
                                r_step  <= r_step + 5'd1;
                                bcd_out <= disp(r_step + 5'd1, cfg_new);
                            end
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_DONE: begin
                    setup_end  <= 1'b0;
                    bcd_enable <= 1'b0;
                    bcd_out    <= c_blank;
                    r_state    <= S_WAIT_OFF;
                end
                S_WAIT_OFF: begin
                    if (!setup_on) begin
                        setup_end <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_config_menu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_menu
//  Description : Scoreboard bench for config_menu (three parameterisations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_menu;

    localparam int CW_A = 15 + 4 * 17;
    localparam int CW_B = 15 + 8 * 25;

    localparam logic [3:0]  TIME_CODES [6] = '{4'hF, 4'h7, 4'h0, 4'hF, 4'h0, 4'h3};
    localparam logic [23:0] TIME_EXPS  [6] = '{24'h02FF20, 24'h02FF07, 24'h02FF60,
                                               24'h03FF15, 24'h03FF50, 24'h03FF05};
    localparam logic [3:0]  PIN_CODES [12] = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                               4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    localparam logic [23:0] PIN_EXPS  [12] = '{24'h049876, 24'h048761, 24'h047612,
                                               24'h046123, 24'h041234, 24'h042345,
                                               24'h05FFF1, 24'h061111, 24'h07FFF0,
                                               24'h080000, 24'h09FFF0, 24'h100000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [3];
    logic        kv    [3];
    logic [3:0]  kc    [3];
    logic        son   [3];

    logic [CW_A-1:0] cold_a, cold_t, cnew_a, cnew_t, exp_cfg;
    logic [CW_B-1:0] cold_b, cnew_b;
    logic [23:0]     bcd_a, bcd_t, bcd_b;
    logic            en_a, en_t, en_b, end_a, end_t, end_b, abt_a, abt_t, abt_b;

    logic [23:0] bcd  [3];
    logic        en   [3];
    logic        send [3];
    logic        abt  [3];

    logic [23:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    always_comb begin
        bcd[0] = bcd_a;  bcd[1] = bcd_t;  bcd[2] = bcd_b;
        en[0]  = en_a;   en[1]  = en_t;   en[2]  = en_b;
        send[0] = end_a; send[1] = end_t; send[2] = end_b;
        abt[0] = abt_a;  abt[1] = abt_t;  abt[2] = abt_b;
    end

    config_menu dut_a (
        .clk(clk), .rst(rst_v[0]), .key_valid(kv[0]), .key_code(kc[0]),
        .setup_on(son[0]), .cfg_old(cold_a), .cfg_new(cnew_a), .bcd_out(bcd_a),
        .bcd_enable(en_a), .setup_end(end_a), .setup_abort(abt_a)
    );

    config_menu #(.TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst(rst_v[1]), .key_valid(kv[1]), .key_code(kc[1]),
        .setup_on(son[1]), .cfg_old(cold_t), .cfg_new(cnew_t), .bcd_out(bcd_t),
        .bcd_enable(en_t), .setup_end(end_t), .setup_abort(abt_t)
    );

    config_menu #(.NUM_PINS(8), .PIN_DIGITS(6)) dut_b (
        .clk(clk), .rst(rst_v[2]), .key_valid(kv[2]), .key_code(kc[2]),
        .setup_on(son[2]), .cfg_old(cold_b), .cfg_new(cnew_b), .bcd_out(bcd_b),
        .bcd_enable(en_b), .setup_end(end_b), .setup_abort(abt_b)
    );

    // One keystroke: strobe high for one cycle, low for one; returns with the display updated.
    task automatic press(input int id, input logic [3:0] code, input logic [23:0] exp);
        exp_q.push_back(exp);
        @(negedge clk); kv[id] = 1'b1; kc[id] = code;
        @(negedge clk); kv[id] = 1'b0;
    endtask

    task automatic start_session(input int id);
        @(negedge clk); son[id] = 1'b1;
        for (int i = 0; i < 20 && en[id] !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic end_session(input int id);
        @(negedge clk); son[id] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [23:0] exp_b(input int s);
        logic [15:0] low;
        if (s == 2 || s == 3)  low = 16'hFF00;
        else if (s % 2 == 0)   low = 16'h0000;
        else                   low = 16'hFFF0;
        return {4'(s / 10), 4'(s % 10), low};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests += 5;
        if (end_a !== 1'b1) begin n_fail++; $display("FAIL reset_setup_end: got %b want 1", end_a); end
        if (en_a !== 1'b0) begin n_fail++; $display("FAIL reset_bcd_enable: got %b want 0", en_a); end
        if (bcd_a !== 24'hFFFFFF) begin n_fail++; $display("FAIL reset_bcd_out: got %h want ffffff", bcd_a); end
        if (abt_a !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abt_a); end
        if (cnew_a !== '0) begin n_fail++; $display("FAIL reset_cfg_new: got %h want 0", cnew_a); end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    endtask

    task automatic test_ignore_outside();
        logic [23:0] e;
        press(0, 4'hF, 24'hFFFFFF);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e) begin n_fail++; $display("FAIL idle_key_display: got %h want %h", bcd_a, e); end
        press(0, 4'h5, 24'hFFFFFF);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e || en_a !== 1'b0) begin n_fail++; $display("FAIL idle_key_enable: bcd %h en %b want %h 0", bcd_a, en_a, e); end
        start_session(0);
        n_tests++;
        if (bcd_a !== 24'h01FFF1) begin n_fail++; $display("FAIL entry_display: got %h want 01fff1", bcd_a); end
        end_session(0);
    endtask

    task automatic test_time_fields();
        logic [23:0] e;
        start_session(0);
        n_tests++;
        if (bcd_a !== 24'h01FFF1) begin n_fail++; $display("FAIL step1_display: got %h want 01fff1", bcd_a); end
        for (int i = 0; i < 6; i++) begin
            press(0, TIME_CODES[i], TIME_EXPS[i]);
            n_tests++; e = exp_q.pop_front();
            if (bcd_a !== e) begin n_fail++; $display("FAIL time_key%0d: bcd_out %h want %h", i, bcd_a, e); end
        end
        n_tests += 2;
        if (cnew_a[7:1] !== 7'd60) begin n_fail++; $display("FAIL bip_time_clamp: got %0d want 60", cnew_a[7:1]); end
        if (cnew_a[14:8] !== 7'd5) begin n_fail++; $display("FAIL lock_time_clamp: got %0d want 5", cnew_a[14:8]); end
    endtask

    task automatic test_pin_and_done();
        logic [23:0] e;
        for (int i = 0; i < 12; i++) begin
            press(0, PIN_CODES[i], PIN_EXPS[i]);
            n_tests++; e = exp_q.pop_front();
            if (bcd_a !== e) begin n_fail++; $display("FAIL pin_key%0d: bcd_out %h want %h", i, bcd_a, e); end
        end
        press(0, 4'hF, 24'h100000);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e) begin n_fail++; $display("FAIL done_cycle_display: got %h want %h", bcd_a, e); end
        @(negedge clk);
        exp_cfg = '0;
        exp_cfg[0] = 1'b1; exp_cfg[7:1] = 7'd60; exp_cfg[14:8] = 7'd5;
        exp_cfg[15 +: 17] = {16'h2345, 1'b1};
        exp_cfg[32 +: 17] = {16'h1111, 1'b1};
        n_tests += 3;
        if (end_a !== 1'b0 || abt_a !== 1'b0) begin n_fail++; $display("FAIL done_handshake: end %b abort %b want 0 0", end_a, abt_a); end
        if (en_a !== 1'b0 || bcd_a !== 24'hFFFFFF) begin n_fail++; $display("FAIL done_display: en %b bcd %h want 0 ffffff", en_a, bcd_a); end
        if (cnew_a !== exp_cfg) begin n_fail++; $display("FAIL done_cfg: got %h want %h", cnew_a, exp_cfg); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (end_a !== 1'b0) begin n_fail++; $display("FAIL wait_off_hold: got %b want 0", end_a); end
        son[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (end_a !== 1'b1) begin n_fail++; $display("FAIL release_end: got %b want 1", end_a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cancel();
        logic [23:0] e;
        start_session(0);
        press(0, 4'h0, 24'h01FFF0);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e) begin n_fail++; $display("FAIL cancel_edit: got %h want %h", bcd_a, e); end
        press(0, 4'hE, 24'h01FFF0);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e) begin n_fail++; $display("FAIL cancel_cycle: got %h want %h", bcd_a, e); end
        @(negedge clk);
        exp_cfg = cold_a;
        exp_cfg[15] = 1'b1;
        n_tests += 2;
        if (end_a !== 1'b0 || abt_a !== 1'b1) begin n_fail++; $display("FAIL cancel_handshake: end %b abort %b want 0 1", end_a, abt_a); end
        if (cnew_a !== exp_cfg) begin n_fail++; $display("FAIL cancel_restore: got %h want %h", cnew_a, exp_cfg); end
        end_session(0);
    endtask

    task automatic test_withdraw();
        logic [23:0] e;
        start_session(0);
        press(0, 4'h0, 24'h01FFF0);
        n_tests++; e = exp_q.pop_front();
        if (bcd_a !== e) begin n_fail++; $display("FAIL withdraw_edit: got %h want %h", bcd_a, e); end
        son[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_tests += 2;
        if (end_a !== 1'b0 || abt_a !== 1'b1) begin n_fail++; $display("FAIL withdraw_handshake: end %b abort %b want 0 1", end_a, abt_a); end
        if (cnew_a !== exp_cfg) begin n_fail++; $display("FAIL withdraw_restore: got %h want %h", cnew_a, exp_cfg); end
        @(negedge clk);
        n_tests++;
        if (end_a !== 1'b1) begin n_fail++; $display("FAIL withdraw_idle: got %b want 1", end_a); end
    endtask

    task automatic test_timeout();
        int cnt;
        logic [23:0] e;
        start_session(1);
        cnt = 0;
        for (int i = 0; i < 100 && en_t === 1'b1; i++) begin
            cnt++;
            @(negedge clk);
        end
        n_tests += 2;
        if (cnt != 17) begin n_fail++; $display("FAIL timeout_cycles: enable high %0d cycles want 17", cnt); end
        if (end_t !== 1'b0 || abt_t !== 1'b1) begin n_fail++; $display("FAIL timeout_abort: end %b abort %b want 0 1", end_t, abt_t); end
        end_session(1);
        start_session(1);
        repeat (14) @(negedge clk);
        press(1, 4'hA, 24'h01FFF0);
        n_tests++; e = exp_q.pop_front();
        if (bcd_t !== e) begin n_fail++; $display("FAIL timeout_key_display: got %h want %h", bcd_t, e); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (en_t !== 1'b1 || end_t !== 1'b1) begin n_fail++; $display("FAIL key_beats_timeout: en %b end %b want 1 1", en_t, end_t); end
        end_session(1);
    endtask

    task automatic test_big_config();
        logic [23:0] e;
        start_session(2);
        n_tests++;
        if (bcd_b !== 24'h01FFF0) begin n_fail++; $display("FAIL big_entry: got %h want 01fff0", bcd_b); end
        for (int s = 2; s <= 18; s++) begin
            press(2, 4'hF, exp_b(s));
            n_tests++; e = exp_q.pop_front();
            if (bcd_b !== e) begin n_fail++; $display("FAIL big_step%0d: bcd_out %h want %h", s, bcd_b, e); end
        end
        press(2, 4'hF, 24'h180000);
        n_tests++; e = exp_q.pop_front();
        if (bcd_b !== e) begin n_fail++; $display("FAIL big_last: got %h want %h", bcd_b, e); end
        @(negedge clk);
        n_tests++;
        if (end_b !== 1'b0 || abt_b !== 1'b0) begin n_fail++; $display("FAIL big_done: end %b abort %b want 0 0", end_b, abt_b); end
        end_session(2);
        start_session(2);
        for (int s = 2; s <= 5; s++) begin
            press(2, 4'hF, exp_b(s));
            n_tests++; e = exp_q.pop_front();
            if (bcd_b !== e) begin n_fail++; $display("FAIL big2_step%0d: bcd_out %h want %h", s, bcd_b, e); end
        end
        press(2, 4'h1, 24'h05FFF1);
        n_tests++; e = exp_q.pop_front();
        if (bcd_b !== e) begin n_fail++; $display("FAIL big_slot1_status: got %h want %h", bcd_b, e); end
        rst_v[2] = 1'b1; son[2] = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if (end_b !== 1'b1 || en_b !== 1'b0 || abt_b !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl: end %b en %b abort %b want 1 0 0", end_b, en_b, abt_b);
        end
        if (bcd_b !== 24'hFFFFFF) begin n_fail++; $display("FAIL midreset_bcd: got %h want ffffff", bcd_b); end
        if (cnew_b !== '0) begin n_fail++; $display("FAIL midreset_cfg: got %h want 0", cnew_b); end
        rst_v[2] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; kv[i] = 1'b0; kc[i] = 4'h0; son[i] = 1'b0;
        end
        cold_a = '0;
        cold_a[0] = 1'b1;
        cold_a[7:1] = 7'd20;
        cold_a[14:8] = 7'd15;
        cold_a[15 +: 17] = {16'h9876, 1'b0};
        cold_a[32 +: 17] = {16'h1111, 1'b1};
        cold_t = '0;
        cold_b = '0;
        exp_cfg = '0;

        test_reset();
        test_ignore_outside();
        test_time_fields();
        test_pin_and_done();
        test_cancel();
        test_withdraw();
        test_timeout();
        test_big_config();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
